// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/DM memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W = 10;
  localparam int MEM_ARB_DATA_W = 32;

  // Which requester owns the read data returning from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_fair_ctr.sv
// Fetch-starvation guard: counts consecutive DM grants while IF is waiting
// and raises force_if once the run reaches MAX_DATA_RUN.
module mem_arb_fair_ctr #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);

  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);

  logic [CW-1:0] run_cnt;

  // IF only needs forcing while it is actually asking.
  assign force_if = if_req && (run_cnt == RUN_MAX);

  // Run counter: clears when IF is idle or served, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      run_cnt <= '0;
    end else if (dm_gnt && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter between instruction fetch (IF) and load/store (DM) on a single
// ported memory. DM has priority; read data is routed back one cycle after
// the grant to whichever requester owned the access.
// Optional fetch-starvation guard enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = MEM_ARB_ADDR_W,
  parameter int DATA_W       = MEM_ARB_DATA_W,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   force_if;
  owner_t owner_q;

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_fair_ctr #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_fair_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt),
    .force_if(force_if)
  );
`else
  logic unused_run_cfg;
  assign force_if       = 1'b0;
  assign unused_run_cfg = (MAX_DATA_RUN == 0);
`endif

  // Grant decision: DM first unless the guard forces IF; nothing while in reset.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && (!dm_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // Memory strobe and command taken from the winner; fetches never write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  // Remember who owns next cycle's read data; stores return nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else if (if_gnt) begin
      owner_q <= OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      owner_q <= OWN_DM;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  // Response steering; a flush drops the fetch response returning this cycle.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    if ((owner_q == OWN_IF) && !if_flush) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_rdata;
    end
    if (owner_q == OWN_DM) begin
      dm_rvalid = 1'b1;
      dm_rdata  = mem_rdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing the single-ported unified instruction/data memory of the RV32I pipelined core between the instruction-fetch (IF) port and the load/store (DM) port. Grants at most one access per cycle, forwards it to the memory, and routes the one-cycle-late read data back to the requester that owns it. Sits between the core's IF/MEM stages and the memory array. Includes an optional fetch-starvation guard and a fetch-response flush for taken branches.

## Interface
- ADDR_W, 10, word-address width (1024 x 32-bit words)
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, max consecutive DM grants while IF waits (fairness only)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_flush  in  1  discard fetch response granted in the previous cycle
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request, held with dm_we/dm_addr/dm_wdata until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data access accepted this cycle
- dm_rvalid  out  1  dm_rdata valid (loads only)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en with mem_we=0

## Operation
- Grant decision combinational from req inputs and fairness state; at most one of if_gnt/dm_gnt high per cycle.
- Default priority: DM over IF (a stalled load/store blocks the pipeline more than a fetch bubble).
- On grant: mem_en=1, mem_addr/mem_we/mem_wdata from winner; IF grant forces mem_we=0, mem_wdata=0. No request: mem_en=0, mem_we=0, addr/wdata=0.
- Owner register (NONE/IF/DM) captures winner of each read grant; writes record NONE.
- Response cycle: owner IF -> if_rvalid=1, if_rdata=mem_rdata; owner DM -> dm_rvalid=1, dm_rdata=mem_rdata. Non-owner rdata reads 0.
- if_flush high while owner is IF suppresses if_rvalid that cycle (if_rdata=0). A fetch granted in the same cycle as if_flush is unaffected.
- Stores: dm_gnt only, no dm_rvalid; write lands in memory at the grant edge.
- Back-to-back grants every cycle supported; throughput one access/cycle.

## Timing
- Reset (async, rst_n=0): if_gnt/dm_gnt follow inputs only after release; owner=NONE, if_rvalid=dm_rvalid=0, rdata outputs 0, run counter 0, mem_en=0. Reset mid-access: in-flight response dropped, no rvalid after release.
- Grant latency: 0 cycles (same cycle as req if won). Read latency: rvalid exactly 1 cycle after gnt.
- Simultaneous if_req and dm_req: DM granted, IF retries next cycle with same address.
- Requester must not change address/data or drop req before gnt; dropping req earlier is a protocol error (behaviour unspecified, not checked).

## Configuration
- MEM_ARB_FAIRNESS_EN defined: run counter increments each cycle DM is granted while if_req=1; when counter == MAX_DATA_RUN and if_req=1, IF wins regardless of dm_req and counter clears. Counter also clears on any IF grant or any cycle with if_req=0. Counter saturates, width $clog2(MAX_DATA_RUN+1).
- Undefined: strict DM priority, no counter; IF can starve indefinitely.

## Structure
- Package mem_arb_pkg: owner enum (OWN_NONE, OWN_IF, OWN_DM), default ADDR_W/DATA_W constants.
- One sub-module: mem_arb_fair_ctr (run counter + force-IF flag), instantiated only under MEM_ARB_FAIRNESS_EN.

## Test plan
- Fetch only: if_req, if_addr=0 with MEM[0]=32'h07800093 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=32'h07800093.
- Contention: if_req addr 1 and dm_req load addr 120 (MEM=85) same cycle -> dm_gnt, next cycle dm_rvalid, dm_rdata=85; IF granted following cycle.
- Store then load: dm store addr 124 wdata 172, then load 124 -> no dm_rvalid for store, load returns 172.
- Flush: IF granted addr 3, if_flush next cycle -> if_rvalid stays 0; IF granted during flush cycle returns data normally.
- Starvation (MEM_ARB_FAIRNESS_EN, MAX_DATA_RUN=4): dm_req and if_req held continuously -> pattern DM x4, IF x1, repeat; without macro -> DM every cycle, IF never.
- Reset: assert rst_n=0 in cycle after read grant -> no rvalid, mem_en=0, owner NONE after release.
